riscv_dmem_wbuf: RTL and testbench
==================================

Name: riscv_dmem_wbuf

Overview:
- Data-memory front end directly downstream of the MEM stage.
- Accepts load/store requests from the core and posts stores into a write buffer, so the pipeline does not wait on memory writes.
- Loads stay ordered with respect to older buffered stores.
- Converts to a valid/ready memory bus with variable read latency; synchronous single-clock domain on the memory side of the async pipeline.

Parameters:
- XLEN, 32, data and address width; strobe width is XLEN/8.
- WBUF_DEPTH, 4, write-buffer entries; power of two, at least 2.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_core_req_valid  in  1  core request valid.
- o_core_req_ready  out  1  request accepted when valid and ready are both high.
- i_core_wr_en  in  1  1 = store, 0 = load.
- i_core_addr  in  XLEN  byte address.
- i_core_strb  in  XLEN/8  store byte strobes.
- i_core_wr_data  in  XLEN  store data.
- o_core_rsp_valid  out  1  one-cycle pulse carrying load data.
- o_core_rsp_data  out  XLEN  load data.
- o_mem_req_valid  out  1  memory request valid.
- i_mem_req_ready  in  1  memory accepts the request.
- o_mem_wr_en  out  1  memory write.
- o_mem_addr  out  XLEN  memory address.
- o_mem_strb  out  XLEN/8  memory strobes.
- o_mem_wr_data  out  XLEN  memory write data.
- i_mem_rsp_valid  in  1  read data valid; reads only, never writes.
- i_mem_rsp_data  in  XLEN  read data.
- o_wbuf_empty  out  1  write buffer empty, for fence.

Behaviour:
- Reset (async assert, sync deassert internally):
  - State is IDLE; FIFO pointers and count are 0.
  - o_core_rsp_valid=0, o_core_rsp_data=0, o_mem_req_valid=0, o_wbuf_empty=1.
- Ready: o_core_req_ready = (state==IDLE) && !full. It does not depend on valid.
- Full: when full, nothing is enqueued, even if a dequeue happens in the same cycle.
- Store accepted: the entry (addr, strb, data) is enqueued at the tail and count increments. The store gets no core response.
- Drain: whenever the FIFO is non-empty and state is IDLE or DRAIN, the head drives the memory bus:
  - o_mem_req_valid=1, o_mem_wr_en=1.
  - Dequeue on valid && ready.
  - Simultaneous enqueue and dequeue leaves count unchanged.
- FSM:
  - IDLE: a load is accepted and latched into the load address register.
    - FIFO empty -> LD_REQ.
    - FIFO non-empty -> DRAIN.
  - DRAIN: stay until count==0 after the dequeue completes -> LD_REQ.
  - LD_REQ: o_mem_req_valid=1, wr_en=0, addr = latched address, strb=0. On ready -> LD_WAIT.
  - LD_WAIT: on i_mem_rsp_valid, register the data, pulse o_core_rsp_valid next cycle -> IDLE.
- Load latency, empty buffer, zero-wait memory (accept at cycle T):
  - o_mem_req_valid at T+1.
  - i_mem_rsp_valid at T+2.
  - o_core_rsp_valid at T+3.
- Memory-side sequencing: stores never issue in LD_REQ/LD_WAIT; only one read is outstanding.
- i_mem_rsp_valid outside LD_WAIT (for example after reset mid-load) is ignored.
- Reset mid-operation discards buffered stores and the pending load.
- o_mem_* outputs other than valid hold their last value when valid=0; the bench does not check them.
- o_wbuf_empty = (count==0), registered from count.

Optional Feature:
- Macro: RISCV_DMEM_FWD_EN.
- Defined, in IDLE, a load is compared on word address (addr[XLEN-1:2]) against all valid entries:
  - If the newest match has strb all ones, its data returns with o_core_rsp_valid at T+1.
  - No memory access, state stays IDLE.
  - Newest match partial -> DRAIN. No match -> LD_REQ even if the FIFO is non-empty; the load bypasses unrelated stores.
- Undefined: the compare logic is absent and any load with a non-empty FIFO goes through DRAIN.

Decomposition:
- XLEN stays in the shared riscv_configs include.
- The FSM state encoding localparams (IDLE, DRAIN, LD_REQ, LD_WAIT) and the word-address slice macro go in the shared package.
- One sub-module, riscv_wbuf_fifo:
  - Parameterised depth, head/tail/count.
  - Exposes all entries for the forwarding compare.

Test Plan:
- Reset, then a load to 0x100 with memory returning 0xDEADBEEF after 3 cycles -> a single o_core_rsp_valid pulse with 0xDEADBEEF, exactly one memory read, o_wbuf_empty stays 1.
- Four stores with i_mem_req_ready=0 -> ready drops after the 4th and the 5th stays stalled. Raise ready -> writes appear in order with correct addr/strb/data and o_wbuf_empty returns to 1.
- Store 0x200=0x11223344, then a load of 0x200, macro undefined, mem ready=1 -> write issues before the read, load data comes from memory, DRAIN is visited.
- Same sequence with RISCV_DMEM_FWD_EN, memory stalled -> rsp 0x11223344 at T+1, no read on the bus. With strb 0011 instead -> DRAIN, then the read.
- Assert i_rstn=0 during LD_WAIT with 2 buffered stores, then deliver a stale i_mem_rsp_valid -> no core response, count 0, state IDLE, outputs at reset values.

Source files
------------

// File: rtl/riscv_dmem_wbuf_pkg.sv
// Shared definitions for the data-memory write-buffer front end: default sizes,
// FSM state encoding and the word-address compare helper.
package riscv_dmem_wbuf_pkg;

    localparam int XLEN_DEFAULT       = 32;
    localparam int WBUF_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_LD_REQ  = 2'd2,
        ST_LD_WAIT = 2'd3
    } wbuf_state_e;

    // Compares byte addresses on their word part; callers zero-extend to 64 bits.
    function automatic logic word_match(input logic [63:0] a, input logic [63:0] b);
        return a[63:2] == b[63:2];
    endfunction

endpackage

// File: rtl/riscv_wbuf_fifo.sv
// Circular store buffer with head/tail/count. With RISCV_DMEM_FWD_EN defined,
// every entry and the head pointer are exported for the load-forwarding compare.
module riscv_wbuf_fifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_push,
    input  logic [XLEN-1:0]    i_push_addr,
    input  logic [XLEN/8-1:0]  i_push_strb,
    input  logic [XLEN-1:0]    i_push_data,
    input  logic               i_pop,
    output logic               o_full,
    output logic [CNT_W-1:0]   o_count,
    output logic [XLEN-1:0]    o_head_addr,
    output logic [XLEN/8-1:0]  o_head_strb,
    output logic [XLEN-1:0]    o_head_data
`ifdef RISCV_DMEM_FWD_EN
    ,
    output logic [PTR_W-1:0]   o_head_ptr,
    output logic [XLEN-1:0]    o_ent_addr [DEPTH],
    output logic [XLEN/8-1:0]  o_ent_strb [DEPTH],
    output logic [XLEN-1:0]    o_ent_data [DEPTH]
`endif
);

    logic [XLEN-1:0]   addr_q [DEPTH];
    logic [XLEN/8-1:0] strb_q [DEPTH];
    logic [XLEN-1:0]   data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;
    logic              push_ok, pop_ok;

    // A full buffer refuses pushes even when the head leaves in the same cycle.
    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && (count_q != '0);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) tail_q <= tail_q + 1'b1;
            if (pop_ok)  head_q <= head_q + 1'b1;
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            addr_q[tail_q] <= i_push_addr;
            strb_q[tail_q] <= i_push_strb;
            data_q[tail_q] <= i_push_data;
        end
    end

    assign o_count     = count_q;
    assign o_head_addr = addr_q[head_q];
    assign o_head_strb = strb_q[head_q];
    assign o_head_data = data_q[head_q];

`ifdef RISCV_DMEM_FWD_EN
    assign o_head_ptr = head_q;
    assign o_ent_addr = addr_q;
    assign o_ent_strb = strb_q;
    assign o_ent_data = data_q;
`endif

endmodule

// File: rtl/riscv_dmem_wbuf.sv
// Data-memory front end: posts stores into a write buffer and keeps loads ordered
// behind them. Define RISCV_DMEM_FWD_EN to forward full-word stores to loads.
module riscv_dmem_wbuf
    import riscv_dmem_wbuf_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int WBUF_DEPTH = WBUF_DEPTH_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_core_req_valid,
    output logic               o_core_req_ready,
    input  logic               i_core_wr_en,
    input  logic [XLEN-1:0]    i_core_addr,
    input  logic [XLEN/8-1:0]  i_core_strb,
    input  logic [XLEN-1:0]    i_core_wr_data,
    output logic               o_core_rsp_valid,
    output logic [XLEN-1:0]    o_core_rsp_data,
    output logic               o_mem_req_valid,
    input  logic               i_mem_req_ready,
    output logic               o_mem_wr_en,
    output logic [XLEN-1:0]    o_mem_addr,
    output logic [XLEN/8-1:0]  o_mem_strb,
    output logic [XLEN-1:0]    o_mem_wr_data,
    input  logic               i_mem_rsp_valid,
    input  logic [XLEN-1:0]    i_mem_rsp_data,
    output logic               o_wbuf_empty
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [1:0]        rst_sync_q;
    logic              rstn_int;
    wbuf_state_e       state_q;
    logic [XLEN-1:0]   ld_addr_q;
    logic              rsp_valid_q;
    logic [XLEN-1:0]   rsp_data_q;
    logic              empty_q;

    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count, cnt_next;
    logic [XLEN-1:0]   head_addr, head_data;
    logic [XLEN/8-1:0] head_strb;
    logic              req_fire, push, pop, ld_fire, ld_phase, drain_en;

    // Reset asserts immediately and releases two clocks after i_rstn rises.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) rst_sync_q <= '0;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rstn_int = rst_sync_q[1];

    assign o_core_req_ready = (state_q == ST_IDLE) && !fifo_full;
    assign req_fire = i_core_req_valid && o_core_req_ready;
    assign push     = req_fire && i_core_wr_en;
    assign ld_fire  = req_fire && !i_core_wr_en;
    assign ld_phase = (state_q == ST_LD_REQ);
    assign drain_en = (fifo_count != '0) && ((state_q == ST_IDLE) || (state_q == ST_DRAIN));
    assign pop      = drain_en && i_mem_req_ready;
    assign cnt_next = fifo_count + CNT_W'(push) - CNT_W'(pop);

    assign o_mem_req_valid = drain_en || ld_phase;
    assign o_mem_wr_en     = !ld_phase;
    assign o_mem_addr      = ld_phase ? ld_addr_q : head_addr;
    assign o_mem_strb      = ld_phase ? '0 : head_strb;
    assign o_mem_wr_data   = head_data;

    assign o_core_rsp_valid = rsp_valid_q;
    assign o_core_rsp_data  = rsp_data_q;
    assign o_wbuf_empty     = empty_q;

`ifdef RISCV_DMEM_FWD_EN
    logic [PTR_W-1:0]  fifo_head;
    logic [XLEN-1:0]   ent_addr [WBUF_DEPTH];
    logic [XLEN/8-1:0] ent_strb [WBUF_DEPTH];
    logic [XLEN-1:0]   ent_data [WBUF_DEPTH];
    logic [PTR_W-1:0]  fwd_idx;
    logic              fwd_hit, fwd_full;
    logic [XLEN-1:0]   fwd_data;

    // Walk oldest to newest so the last match seen is the youngest store.
    always_comb begin
        fwd_idx  = '0;
        fwd_hit  = 1'b0;
        fwd_full = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            fwd_idx = fifo_head + PTR_W'(i);
            if ((CNT_W'(i) < fifo_count) && word_match(64'(ent_addr[fwd_idx]), 64'(i_core_addr))) begin
                fwd_hit  = 1'b1;
                fwd_full = &ent_strb[fwd_idx];
                fwd_data = ent_data[fwd_idx];
            end
        end
    end
`endif

    riscv_wbuf_fifo #(.XLEN(XLEN), .DEPTH(WBUF_DEPTH)) u_fifo (
        .i_clk       (i_clk),
        .i_rstn      (rstn_int),
        .i_push      (push),
        .i_push_addr (i_core_addr),
        .i_push_strb (i_core_strb),
        .i_push_data (i_core_wr_data),
        .i_pop       (pop),
        .o_full      (fifo_full),
        .o_count     (fifo_count),
        .o_head_addr (head_addr),
        .o_head_strb (head_strb),
        .o_head_data (head_data)
`ifdef RISCV_DMEM_FWD_EN
        ,
        .o_head_ptr  (fifo_head),
        .o_ent_addr  (ent_addr),
        .o_ent_strb  (ent_strb),
        .o_ent_data  (ent_data)
`endif
    );

    always_ff @(posedge i_clk or negedge rstn_int) begin
        if (!rstn_int) begin
            state_q     <= ST_IDLE;
            ld_addr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            empty_q     <= 1'b1;
        end else begin
            rsp_valid_q <= 1'b0;
            empty_q     <= (cnt_next == '0);
            case (state_q)
                ST_IDLE: begin
                    if (ld_fire) begin
                        ld_addr_q <= i_core_addr;
`ifdef RISCV_DMEM_FWD_EN
                        if (fwd_hit && fwd_full) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= fwd_data;
                        end else if (fwd_hit) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            state_q <= ST_LD_REQ;
                        end
`else
                        state_q <= (fifo_count != '0) ? ST_DRAIN : ST_LD_REQ;
`endif
                    end
                end
                ST_DRAIN: begin
                    if (cnt_next == '0) state_q <= ST_LD_REQ;
                end
                ST_LD_REQ: begin
                    if (i_mem_req_ready) state_q <= ST_LD_WAIT;
                end
                ST_LD_WAIT: begin
                    if (i_mem_rsp_valid) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= i_mem_rsp_data;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_dmem_wbuf.sv
// Directed bench for riscv_dmem_wbuf; covers both builds of RISCV_DMEM_FWD_EN.
module tb_riscv_dmem_wbuf;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_core_req_valid, i_core_wr_en;
    logic [31:0] i_core_addr, i_core_wr_data;
    logic [3:0]  i_core_strb;
    logic        o_core_req_ready, o_core_rsp_valid;
    logic [31:0] o_core_rsp_data;
    logic        o_mem_req_valid, i_mem_req_ready, o_mem_wr_en;
    logic [31:0] o_mem_addr, o_mem_wr_data;
    logic [3:0]  o_mem_strb;
    logic        i_mem_rsp_valid;
    logic [31:0] i_mem_rsp_data;
    logic        o_wbuf_empty;

    always #5 clk = ~clk;

    riscv_dmem_wbuf dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_core_req_valid(i_core_req_valid), .o_core_req_ready(o_core_req_ready),
        .i_core_wr_en(i_core_wr_en), .i_core_addr(i_core_addr),
        .i_core_strb(i_core_strb), .i_core_wr_data(i_core_wr_data),
        .o_core_rsp_valid(o_core_rsp_valid), .o_core_rsp_data(o_core_rsp_data),
        .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
        .o_mem_wr_en(o_mem_wr_en), .o_mem_addr(o_mem_addr),
        .o_mem_strb(o_mem_strb), .o_mem_wr_data(o_mem_wr_data),
        .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_data(i_mem_rsp_data),
        .o_wbuf_empty(o_wbuf_empty)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;   // store data, or what memory returns for a load
        int          lat;
        logic [31:0] exp;    // expected load response
    } vec_t;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor, sampled on the falling edge ahead of the capturing rising edge.
    int          rsp_cnt = 0, rsp_cyc = 0, rd_cnt = 0, rd_cyc = 0, wr_cnt = 0, nonempty_cnt = 0;
    logic [31:0] rsp_seen = '0;
    wr_t         wlog [64];
    always @(negedge clk) begin
        if (o_core_rsp_valid) begin
            rsp_cnt  = rsp_cnt + 1;
            rsp_cyc  = cyc;
            rsp_seen = o_core_rsp_data;
        end
        if (!o_wbuf_empty) nonempty_cnt = nonempty_cnt + 1;
        if (o_mem_req_valid && i_mem_req_ready) begin
            if (o_mem_wr_en) begin
                if (wr_cnt < 64) wlog[wr_cnt] = '{o_mem_addr, o_mem_strb, o_mem_wr_data, cyc};
                wr_cnt = wr_cnt + 1;
            end else begin
                rd_cnt = rd_cnt + 1;
                rd_cyc = cyc;
            end
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic tmo(input string nm);
        n_chk++;
        $display("FAIL %s: timed out, got no event, expected one", nm);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output int t);
        bit ok = 0;
        i_core_req_valid = 1'b1; i_core_wr_en = wr;
        i_core_addr = a; i_core_strb = s; i_core_wr_data = d;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_core_req_ready) begin ok = 1; break; end
        end
        t = cyc;
        if (!ok) tmo("core_accept");
        @(posedge clk); #1;
        i_core_req_valid = 1'b0;
    endtask

    // Waits for the read handshake, then returns data lat cycles later.
    task automatic mem_read(input int lat, input logic [31:0] d, output int acc);
        bit ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_mem_req_valid && !o_mem_wr_en && i_mem_req_ready) begin ok = 1; break; end
        end
        acc = cyc;
        if (!ok) tmo("mem_read_req");
        repeat (lat) @(posedge clk);
        #1; i_mem_rsp_valid = 1'b1; i_mem_rsp_data = d;
        @(posedge clk); #1;
        i_mem_rsp_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n0);
        bit ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (rsp_cnt > n0) begin ok = 1; break; end
            tick(1);
        end
        if (!ok) tmo("core_rsp");
    endtask

    task automatic wait_wr(input int n);
        bit ok = 0;
        for (int k = 0; k < 60; k++) begin
            if (wr_cnt >= n) begin ok = 1; break; end
            tick(1);
        end
        if (!ok) tmo("mem_write");
    endtask

    vec_t        vt [6];
    logic [31:0] sa [5], sd [5];
    logic [3:0]  ss [5];
    int t, acc, n0, r0, w0, e0;
    bit stall_ok;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b0, 32'h0000_0100, 4'h0, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF};
        vt[1] = '{1'b1, 32'h0000_0104, 4'hF, 32'hA5A5_A5A5, 0, 32'h0};
        vt[2] = '{1'b0, 32'h0000_0104, 4'h0, 32'h0BAD_F00D, 1, 32'h0BAD_F00D};
        vt[3] = '{1'b1, 32'h0000_0000, 4'h1, 32'h0000_00FF, 0, 32'h0};
        vt[4] = '{1'b0, 32'hFFFF_FFFC, 4'h0, 32'h1234_5678, 2, 32'h1234_5678};
        vt[5] = '{1'b1, 32'hFFFF_FFFC, 4'h8, 32'hAB00_0000, 0, 32'h0};
        for (int i = 0; i < 5; i++) begin
            sa[i] = 32'h300 + 32'(4 * i);
            sd[i] = 32'hA000_0000 + 32'(i * 32'h0101);
        end
        ss[0] = 4'hF; ss[1] = 4'h1; ss[2] = 4'h6; ss[3] = 4'h8; ss[4] = 4'hC;

        rstn = 1'b0; i_core_req_valid = 0; i_core_wr_en = 0; i_core_addr = 0;
        i_core_strb = 0; i_core_wr_data = 0; i_mem_req_ready = 1; i_mem_rsp_valid = 0;
        i_mem_rsp_data = 0;
        tick(2);
        chk("rst_rsp_valid", 64'(o_core_rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(o_core_rsp_data), 64'd0);
        chk("rst_mem_valid", 64'(o_mem_req_valid), 64'd0);
        chk("rst_wbuf_empty", 64'(o_wbuf_empty), 64'd1);
        chk("rst_req_ready", 64'(o_core_req_ready), 64'd1);
        rstn = 1'b1;
        tick(4);

        // Table: loads with an empty buffer and zero-wait memory, stores draining.
        for (int i = 0; i < 6; i++) begin
            if (vt[i].wr) begin
                w0 = wr_cnt;
                issue(1'b1, vt[i].addr, vt[i].strb, vt[i].data, t);
                wait_wr(w0 + 1);
                chk($sformatf("v%0d_wr_addr", i), 64'(wlog[w0].addr), 64'(vt[i].addr));
                chk($sformatf("v%0d_wr_strb_data", i), 64'({wlog[w0].strb, wlog[w0].data}),
                    64'({vt[i].strb, vt[i].data}));
                chk($sformatf("v%0d_empty_after", i), 64'(o_wbuf_empty), 64'd1);
            end else begin
                n0 = rsp_cnt; r0 = rd_cnt; e0 = nonempty_cnt;
                issue(1'b0, vt[i].addr, 4'h0, 32'h0, t);
                mem_read(vt[i].lat, vt[i].data, acc);
                wait_rsp(n0);
                tick(2);
                chk($sformatf("v%0d_rsp_data", i), 64'(rsp_seen), 64'(vt[i].exp));
                chk($sformatf("v%0d_rsp_latency", i), 64'(rsp_cyc - t), 64'(vt[i].lat + 2));
                chk($sformatf("v%0d_req_latency", i), 64'(acc - t), 64'd1);
                chk($sformatf("v%0d_read_count", i), 64'(rd_cnt - r0), 64'd1);
                chk($sformatf("v%0d_rsp_pulses", i), 64'(rsp_cnt - n0), 64'd1);
                chk($sformatf("v%0d_empty_held", i), 64'(nonempty_cnt - e0), 64'd0);
            end
        end

        // Fill the buffer while memory stalls; the fifth store must wait.
        i_mem_req_ready = 1'b0;
        w0 = wr_cnt;
        for (int i = 0; i < 4; i++) issue(1'b1, sa[i], ss[i], sd[i], t);
        chk("full_ready_low", 64'(o_core_req_ready), 64'd0);
        chk("full_wbuf_empty", 64'(o_wbuf_empty), 64'd0);
        i_core_req_valid = 1'b1; i_core_wr_en = 1'b1;
        i_core_addr = sa[4]; i_core_strb = ss[4]; i_core_wr_data = sd[4];
        stall_ok = 1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            if (o_core_req_ready) stall_ok = 0;
        end
        chk("fifth_store_stalled", 64'(stall_ok), 64'd1);
        chk("no_write_while_stalled", 64'(wr_cnt - w0), 64'd0);
        i_mem_req_ready = 1'b1;
        stall_ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_core_req_ready) begin stall_ok = 1; break; end
        end
        if (!stall_ok) tmo("fifth_store_accept");
        @(posedge clk); #1;
        i_core_req_valid = 1'b0;
        wait_wr(w0 + 5);
        tick(2);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("order%0d_addr", i), 64'(wlog[w0 + i].addr), 64'(sa[i]));
            chk($sformatf("order%0d_strb_data", i), 64'({wlog[w0 + i].strb, wlog[w0 + i].data}),
                64'({ss[i], sd[i]}));
        end
        chk("drained_empty", 64'(o_wbuf_empty), 64'd1);

`ifndef RISCV_DMEM_FWD_EN
        // Load right behind a buffered store to the same word goes through DRAIN.
        w0 = wr_cnt; n0 = rsp_cnt; r0 = rd_cnt;
        issue(1'b1, 32'h200, 4'hF, 32'h1122_3344, t);
        issue(1'b0, 32'h200, 4'h0, 32'h0, t);
        mem_read(1, 32'hCAFE_F00D, acc);
        wait_rsp(n0);
        tick(2);
        chk("drain_wr_data", 64'(wlog[w0].data), 64'h1122_3344);
        chk("drain_wr_cycle", 64'(wlog[w0].cyc - t), 64'd0);
        chk("drain_rd_cycle", 64'(acc - t), 64'd2);
        chk("drain_rsp_data", 64'(rsp_seen), 64'hCAFE_F00D);
        chk("drain_rsp_latency", 64'(rsp_cyc - t), 64'd4);
        chk("drain_reads", 64'(rd_cnt - r0), 64'd1);
`else
        // Full-word forward from a stalled buffer, byte offset within the word.
        i_mem_req_ready = 1'b0;
        n0 = rsp_cnt; r0 = rd_cnt; w0 = wr_cnt;
        issue(1'b1, 32'h200, 4'hF, 32'h1122_3344, t);
        issue(1'b0, 32'h202, 4'h0, 32'h0, t);
        wait_rsp(n0);
        tick(3);
        chk("fwd_rsp_data", 64'(rsp_seen), 64'h1122_3344);
        chk("fwd_rsp_latency", 64'(rsp_cyc - t), 64'd1);
        chk("fwd_no_read", 64'(rd_cnt - r0), 64'd0);
        chk("fwd_ready_idle", 64'(o_core_req_ready), 64'd1);
        i_mem_req_ready = 1'b1;
        wait_wr(w0 + 1);
        tick(1);
        i_mem_req_ready = 1'b0;

        // Partial-strobe match must drain first, then read memory.
        n0 = rsp_cnt; r0 = rd_cnt; w0 = wr_cnt;
        issue(1'b1, 32'h200, 4'h3, 32'h5566_7788, t);
        issue(1'b0, 32'h200, 4'h0, 32'h0, t);
        tick(3);
        chk("partial_no_rsp", 64'(rsp_cnt - n0), 64'd0);
        chk("partial_no_read", 64'(rd_cnt - r0), 64'd0);
        i_mem_req_ready = 1'b1;
        mem_read(1, 32'h99AA_BBCC, acc);
        wait_rsp(n0);
        chk("partial_wr_data", 64'(wlog[w0].data), 64'h5566_7788);
        chk("partial_wr_before_rd", 64'(wlog[w0].cyc < acc), 64'd1);
        chk("partial_rsp_data", 64'(rsp_seen), 64'h99AA_BBCC);

        // Unrelated store: load bypasses it and reads first.
        tick(2);
        i_mem_req_ready = 1'b0;
        n0 = rsp_cnt; w0 = wr_cnt;
        issue(1'b1, 32'h400, 4'hF, 32'h4444_4444, t);
        issue(1'b0, 32'h500, 4'h0, 32'h0, t);
        chk("bypass_rd_valid", 64'({o_mem_req_valid, o_mem_wr_en}), 64'b10);
        chk("bypass_rd_addr", 64'(o_mem_addr), 64'h500);
        i_mem_req_ready = 1'b1;
        mem_read(1, 32'h7777_0000, acc);
        wait_rsp(n0);
        wait_wr(w0 + 1);
        chk("bypass_rsp_data", 64'(rsp_seen), 64'h7777_0000);
        chk("bypass_rd_before_wr", 64'(acc < wlog[w0].cyc), 64'd1);
        chk("bypass_wr_addr", 64'(wlog[w0].addr), 64'h400);
`endif

        // Reset in the middle of a load with two stores buffered.
        tick(2);
        i_mem_req_ready = 1'b0;
        issue(1'b1, 32'h600, 4'hF, 32'h6666_0000, t);
        issue(1'b1, 32'h604, 4'hF, 32'h6666_0004, t);
        issue(1'b0, 32'h700, 4'h0, 32'h0, t);
`ifdef RISCV_DMEM_FWD_EN
        i_mem_req_ready = 1'b1;
        stall_ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_mem_req_valid && !o_mem_wr_en) begin stall_ok = 1; break; end
        end
        if (!stall_ok) tmo("reset_load_read");
        @(posedge clk); #1;
`else
        tick(2);
`endif
        rstn = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 64'(o_core_rsp_valid), 64'd0);
        chk("mid_rst_rsp_data", 64'(o_core_rsp_data), 64'd0);
        chk("mid_rst_mem_valid", 64'(o_mem_req_valid), 64'd0);
        chk("mid_rst_empty", 64'(o_wbuf_empty), 64'd1);
        tick(2);
        n0 = rsp_cnt; r0 = rd_cnt; w0 = wr_cnt;
        i_mem_req_ready = 1'b1;
        rstn = 1'b1;
        tick(4);
        i_mem_rsp_valid = 1'b1; i_mem_rsp_data = 32'hDEAD_0001;
        tick(1);
        i_mem_rsp_valid = 1'b0;
        tick(5);
        chk("stale_no_rsp", 64'(rsp_cnt - n0), 64'd0);
        chk("stale_rsp_data", 64'(o_core_rsp_data), 64'd0);
        chk("post_rst_no_writes", 64'(wr_cnt - w0), 64'd0);
        chk("post_rst_no_reads", 64'(rd_cnt - r0), 64'd0);
        chk("post_rst_mem_valid", 64'(o_mem_req_valid), 64'd0);
        chk("post_rst_empty", 64'(o_wbuf_empty), 64'd1);
        chk("post_rst_ready", 64'(o_core_req_ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
